// File: rtl/osc_pkg.sv
// Shared oscilloscope datapath types: capture FSM states, default sample width
// and the trigger edge encoding.
package osc_pkg;

    localparam int DEF_DATA_W = 12;

    localparam logic TRIG_RISING  = 1'b0;
    localparam logic TRIG_FALLING = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        PRE_FILL,
        WAIT_TRIG,
        POST_FILL,
        DONE
    } trig_state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port capture buffer: synchronous write, registered read.
// Only the read register is reset so the array still maps onto block RAM.
module capture_ram #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata <= '0;
        else     rdata <= mem[raddr];
    end

endmodule

// File: rtl/trigger_capture.sv
// Level-crossing trigger with pre/post-trigger circular capture and a
// trigger-aligned read port. Define TRIG_AUTO_EN to build the auto-trigger timeout.
module trigger_capture
    import osc_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int DEPTH        = 1024,
    parameter int ADDR_W       = $clog2(DEPTH),
    parameter int AUTO_TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_edge,
    input  logic [ADDR_W-1:0] pre_count,
    input  logic              arm,
    output logic              busy,
    output logic              capture_done,
    output logic              trig_forced,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || AUTO_TIMEOUT < 1) begin : g_bad_cfg
        $error("trigger_capture: DEPTH must be a power of two >= 4, AUTO_TIMEOUT >= 1");
    end

    // sample_valid has no back-pressure: one sample is consumed on every rising
    // edge where it is high, except in the arm cycle where the sample is dropped.
    trig_state_t       state;
    logic [ADDR_W-1:0] wr_ptr, start_addr, pre_lat;
    logic [ADDR_W:0]   fill_cnt, fill_nx, post_total;
    logic [DATA_W-1:0] prev_sample;
    logic              prev_valid;
    logic              wr_en, crossing, auto_hit;

    assign fill_nx    = fill_cnt + (ADDR_W+1)'(1);
    assign post_total = (ADDR_W+1)'(DEPTH) - {1'b0, pre_lat};

    assign wr_en = sample_valid && !arm &&
                   ((state == PRE_FILL && pre_lat != '0) ||
                    state == WAIT_TRIG || state == POST_FILL);

    assign crossing = prev_valid &&
        ((trig_edge == TRIG_RISING)
            ? (prev_sample < trig_level && trig_level <= sample_in)
            : (prev_sample > trig_level && trig_level >= sample_in));

`ifdef TRIG_AUTO_EN
    localparam int AUTO_W = $clog2(AUTO_TIMEOUT + 1);
    logic [AUTO_W-1:0] auto_cnt;
    assign auto_hit = (auto_cnt == AUTO_W'(AUTO_TIMEOUT));
`else
    assign auto_hit    = 1'b0;
    assign trig_forced = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            start_addr   <= '0;
            pre_lat      <= '0;
            fill_cnt     <= '0;
            prev_sample  <= '0;
            prev_valid   <= 1'b0;
            busy         <= 1'b0;
            capture_done <= 1'b0;
`ifdef TRIG_AUTO_EN
            auto_cnt     <= '0;
            trig_forced  <= 1'b0;
`endif
        end else if (arm) begin
            // pre_count is ADDR_W wide, so it can never exceed DEPTH-1.
            state        <= PRE_FILL;
            pre_lat      <= pre_count;
            fill_cnt     <= '0;
            prev_valid   <= 1'b0;
            busy         <= 1'b1;
            capture_done <= 1'b0;
`ifdef TRIG_AUTO_EN
            auto_cnt     <= '0;
            trig_forced  <= 1'b0;
`endif
        end else begin
            if (wr_en) begin
                wr_ptr      <= wr_ptr + ADDR_W'(1);
                prev_sample <= sample_in;
                prev_valid  <= 1'b1;
            end
            case (state)
                PRE_FILL: begin
                    if (pre_lat == '0) begin
                        state <= WAIT_TRIG;
                    end else if (wr_en) begin
                        fill_cnt <= fill_nx;
                        if (fill_nx == {1'b0, pre_lat}) state <= WAIT_TRIG;
                    end
                end
                WAIT_TRIG: begin
                    if (wr_en) begin
                        if (crossing || auto_hit) begin
                            start_addr <= wr_ptr - pre_lat;
                            fill_cnt   <= (ADDR_W+1)'(1);
`ifdef TRIG_AUTO_EN
                            trig_forced <= !crossing;
`endif
                            if (post_total == (ADDR_W+1)'(1)) begin
                                state        <= DONE;
                                busy         <= 1'b0;
                                capture_done <= 1'b1;
                            end else begin
                                state <= POST_FILL;
                            end
                        end else begin
`ifdef TRIG_AUTO_EN
                            auto_cnt <= auto_cnt + AUTO_W'(1);
`endif
                        end
                    end
                end
                POST_FILL: begin
                    if (wr_en) begin
                        fill_cnt <= fill_nx;
                        if (fill_nx == post_total) begin
                            state        <= DONE;
                            busy         <= 1'b0;
                            capture_done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    capture_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (sample_in),
        .raddr (start_addr + rd_addr),
        .rdata (rd_data)
    );

endmodule
